// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes, funct codes and datapath selects.
// Also used by the single-cycle variant, which needs the ALU codes only.
package mips_ctrl_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ORIEX    = 4'd10,
        S_IMMWB    = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps (alu_op, funct) to the 3-bit ALU operation; purely combinational, zero latency.
// No flow control: output follows inputs in the same cycle.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALUC_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALUC_ADD;
            ALUOP_SUB: alu_control = ALUC_SUB;
            ALUOP_OR:  alu_control = ALUC_OR;
            default: begin
                case (funct)
                    FN_ADD:  alu_control = ALUC_ADD;
                    FN_SUB:  alu_control = ALUC_SUB;
                    FN_AND:  alu_control = ALUC_AND;
                    FN_OR:   alu_control = ALUC_OR;
                    FN_SLT:  alu_control = ALUC_SLT;
                    // unknown R-type funct falls back to add rather than trapping
                    default: alu_control = ALUC_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS core: 3 to 5 cycles per instruction, outputs decoded from state.
// No backpressure: one state per clock; write strobes are forced low while reset is asserted.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_WIDTH = 4,
    parameter bit HAS_BNE     = 1'b1,
    parameter bit HAS_ORI     = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             opcode,
    input  logic [5:0]             funct,
    input  logic                   zero,
    output logic                   pc_enable,
    output logic [1:0]             pc_src,
    output logic                   iord,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   reg_dst,
    output logic                   mem_to_reg,
    output logic                   reg_write,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic                   imm_zero_ext,
    output logic [2:0]             alu_control,
    output logic                   illegal_op,
    output logic [STATE_WIDTH-1:0] state_o
);

    state_t     state;
    state_t     next_state;
    state_t     decode_next;
    logic       op_legal;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       branch;
    logic       is_bne;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       illegal_raw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        op_legal    = 1'b1;
        decode_next = S_FETCH;
        case (opcode)
            OP_LW, OP_SW: decode_next = S_MEMADR;
            OP_RTYPE:     decode_next = S_EXECUTE;
            OP_BEQ:       decode_next = S_BRANCH;
            OP_BNE: begin
                decode_next = S_BRANCH;
                op_legal    = HAS_BNE;
            end
            OP_ADDI:      decode_next = S_ADDIEX;
            OP_ORI: begin
                decode_next = S_ORIEX;
                op_legal    = HAS_ORI;
            end
            OP_J:         decode_next = S_JUMP;
            default:      op_legal = 1'b0;
        endcase
        if (!op_legal) begin
            decode_next = S_FETCH;
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:   next_state = S_DECODE;
            S_DECODE:  next_state = decode_next;
            S_MEMADR: begin
                if (opcode == OP_LW) begin
                    next_state = S_MEMREAD;
                end else if (opcode == OP_SW) begin
                    next_state = S_MEMWRITE;
                end
            end
            S_MEMREAD: next_state = S_MEMWB;
            S_EXECUTE: next_state = S_ALUWB;
            S_ADDIEX:  next_state = S_IMMWB;
            S_ORIEX:   next_state = S_IMMWB;
            default:   next_state = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        branch        = 1'b0;
        pc_src        = PCSRC_ALU;
        iord          = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write_raw = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        imm_zero_ext  = 1'b0;
        alu_op        = ALUOP_ADD;
        illegal_raw   = 1'b0;
        case (state)
            S_DECODE: begin
                alu_src_b   = SRCB_IMMSH;
                illegal_raw = !op_legal;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg    = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                iord          = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst       = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                branch    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ORIEX: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_IMM;
                alu_op       = ALUOP_OR;
                imm_zero_ext = 1'b1;
            end
            S_IMMWB: reg_write_raw = 1'b1;
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            // FETCH and any unused encoding drive the fetch controls
            default: begin
                ir_write_raw = 1'b1;
                alu_src_b    = SRCB_FOUR;
                pc_write     = 1'b1;
            end
        endcase
    end

    mips_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (alu_control)
    );

    // opcode is held by the IR outside FETCH, so the bne sense is safe to take directly
    assign is_bne     = (opcode == OP_BNE);
    assign pc_enable  = reset & (pc_write | (branch & (zero ^ is_bne)));
    assign mem_write  = reset & mem_write_raw;
    assign ir_write   = reset & ir_write_raw;
    assign reg_write  = reset & reg_write_raw;
    assign illegal_op = reset & illegal_raw;
    assign state_o    = STATE_WIDTH'(state);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle control FSM: expected per-cycle control words are queued, then compared each cycle.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_enable;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zero_ext;
    logic [2:0] alu_control;
    logic       illegal_op;
    logic [3:0] state_o;

    typedef struct packed {
        logic       pc_enable;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       imm_zero_ext;
        logic [2:0] alu_control;
        logic       illegal_op;
        logic [3:0] state;
    } ctl_t;

    ctl_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mips_multicycle_control dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .funct        (funct),
        .zero         (zero),
        .pc_enable    (pc_enable),
        .pc_src       (pc_src),
        .iord         (iord),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .reg_dst      (reg_dst),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .imm_zero_ext (imm_zero_ext),
        .alu_control  (alu_control),
        .illegal_op   (illegal_op),
        .state_o      (state_o)
    );

    function automatic ctl_t blank(input logic [3:0] st);
        ctl_t e;
        e = '0;
        e.alu_control = 3'b010;
        e.state = st;
        return e;
    endfunction

    function automatic ctl_t rst_e();
        ctl_t e;
        e = blank(4'd0);
        e.alu_src_b = 2'b01;
        return e;
    endfunction

    function automatic ctl_t fetch_e();
        ctl_t e;
        e = rst_e();
        e.ir_write  = 1'b1;
        e.pc_enable = 1'b1;
        return e;
    endfunction

    function automatic ctl_t decode_e(input logic ill);
        ctl_t e;
        e = blank(4'd1);
        e.alu_src_b  = 2'b11;
        e.illegal_op = ill;
        return e;
    endfunction

    function automatic ctl_t observe();
        ctl_t o;
        o.pc_enable    = pc_enable;
        o.pc_src       = pc_src;
        o.iord         = iord;
        o.mem_write    = mem_write;
        o.ir_write     = ir_write;
        o.reg_dst      = reg_dst;
        o.mem_to_reg   = mem_to_reg;
        o.reg_write    = reg_write;
        o.alu_src_a    = alu_src_a;
        o.alu_src_b    = alu_src_b;
        o.imm_zero_ext = imm_zero_ext;
        o.alu_control  = alu_control;
        o.illegal_op   = illegal_op;
        o.state        = state_o;
        return o;
    endfunction

    task automatic push(input ctl_t e);
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag);
        ctl_t e;
        ctl_t o;
        e = sb.pop_front();
        o = observe();
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h (state %0d vs %0d)", tag, o, e, o.state, e.state);
        end
    endtask

    // one compare per cycle at the falling edge; returns just after the next rising edge
    task automatic drain(input string tag);
        while (sb.size() > 0) begin
            @(negedge clk);
            cmp(tag);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        opcode = op;
        funct  = fn;
        zero   = z;
    endtask

    task automatic run_branch(input logic [5:0] op, input logic z, input logic take, input string tag);
        ctl_t e;
        set_instr(op, 6'd0, z);
        push(fetch_e());
        push(decode_e(1'b0));
        e = blank(4'd8);
        e.alu_src_a   = 1'b1;
        e.alu_control = 3'b110;
        e.pc_src      = 2'b01;
        e.pc_enable   = take;
        push(e);
        drain(tag);
    endtask

    task automatic run_rtype(input logic [5:0] fn, input logic [2:0] aluc, input string tag);
        ctl_t e;
        set_instr(6'b000000, fn, 1'b0);
        push(fetch_e());
        push(decode_e(1'b0));
        e = blank(4'd6);
        e.alu_src_a   = 1'b1;
        e.alu_control = aluc;
        push(e);
        e = blank(4'd7);
        e.reg_dst   = 1'b1;
        e.reg_write = 1'b1;
        push(e);
        drain(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d assertions so far", n_assert);
        $fatal(1, "watchdog expired");
    end

    initial begin
        ctl_t e;
        reset = 1'b0;
        set_instr(6'b000000, 6'd0, 1'b0);

        // held in reset for three cycles: selects at fetch values, all strobes low
        push(rst_e());
        push(rst_e());
        push(rst_e());
        drain("reset");
        reset = 1'b1;

        // lw: five cycles
        set_instr(6'b100011, 6'd0, 1'b0);
        push(fetch_e());
        push(decode_e(1'b0));
        e = blank(4'd2);
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'b10;
        push(e);
        e = blank(4'd3);
        e.iord = 1'b1;
        push(e);
        e = blank(4'd4);
        e.mem_to_reg = 1'b1;
        e.reg_write  = 1'b1;
        push(e);
        drain("lw");

        run_branch(6'b000100, 1'b1, 1'b1, "beq_taken");
        run_branch(6'b000100, 1'b0, 1'b0, "beq_not_taken");
        run_branch(6'b000101, 1'b0, 1'b1, "bne_taken");
        run_branch(6'b000101, 1'b1, 1'b0, "bne_not_taken");

        run_rtype(6'b101010, 3'b111, "r_slt");
        run_rtype(6'b100010, 3'b110, "r_sub");
        run_rtype(6'b100100, 3'b000, "r_and");
        run_rtype(6'b111000, 3'b010, "r_unknown_funct");

        // unsupported opcode: pulse in DECODE, then straight back to FETCH
        set_instr(6'b111111, 6'd0, 1'b0);
        push(fetch_e());
        push(decode_e(1'b1));
        drain("illegal");

        // j: the FETCH check at the start confirms the illegal op returned after two cycles
        set_instr(6'b000010, 6'd0, 1'b0);
        push(fetch_e());
        push(decode_e(1'b0));
        e = blank(4'd12);
        e.pc_src    = 2'b10;
        e.pc_enable = 1'b1;
        push(e);
        drain("jump");

        set_instr(6'b001000, 6'd0, 1'b1);
        push(fetch_e());
        push(decode_e(1'b0));
        e = blank(4'd9);
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'b10;
        push(e);
        e = blank(4'd11);
        e.reg_write = 1'b1;
        push(e);
        drain("addi");

        set_instr(6'b001101, 6'd0, 1'b0);
        push(fetch_e());
        push(decode_e(1'b0));
        e = blank(4'd10);
        e.alu_src_a    = 1'b1;
        e.alu_src_b    = 2'b10;
        e.alu_control  = 3'b001;
        e.imm_zero_ext = 1'b1;
        push(e);
        e = blank(4'd11);
        e.reg_write = 1'b1;
        push(e);
        drain("ori");

        // sw aborted by reset while in MEMWRITE
        set_instr(6'b101011, 6'd0, 1'b0);
        push(fetch_e());
        push(decode_e(1'b0));
        e = blank(4'd2);
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'b10;
        push(e);
        drain("sw");
        e = blank(4'd5);
        e.iord      = 1'b1;
        e.mem_write = 1'b1;
        push(e);
        @(negedge clk);
        cmp("sw_memwrite");
        reset = 1'b0;
        #1;
        push(rst_e());
        cmp("sw_abort");
        @(posedge clk);
        #1;
        push(rst_e());
        @(negedge clk);
        cmp("sw_reset_held");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // after release the next edge executes FETCH, so the next instruction decodes normally
        set_instr(6'b000010, 6'd0, 1'b0);
        push(fetch_e());
        push(decode_e(1'b0));
        drain("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
